mac_col_feeder: RTL and testbench
=================================

# mac_col_feeder

Issue-side sequencer for the MAC column chain. On `start` it reads key vectors, then query vectors, from the activation SRAM and drives them onto the first column's `q_in`/`i_inst` pair: a load phase, an execute phase and a drain phase. It is the transmitter for the column's load/execute protocol. It sits between the core controller and column 0; downstream columns receive the stream through the chained `q_out`/`o_inst`.

## Interface

Parameters
- `bw`, 8: element width.
- `pr`, 8: elements per vector (bus width `pr*bw`).
- `col`, 8: columns in the chain.
- `addr_w`, 11: SRAM address width.
- `qcnt_w`, 8: width of the query-count field.

Ports
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  one-cycle pulse; accepted only in IDLE.
- `key_base`  in  addr_w  address of key vector for column 0; sampled on accepted `start`.
- `q_base`  in  addr_w  address of first query vector; sampled on `start`.
- `n_q`  in  qcnt_w  number of query vectors; sampled on `start`.
- `mem_rd`  out  1  SRAM read enable; read data valid 1 cycle later.
- `mem_addr`  out  addr_w  SRAM read address.
- `mem_rdata`  in  pr*bw  SRAM read data.
- `q_out`  out  pr*bw  vector to column 0 `q_in`.
- `inst`  out  2  to column 0 `i_inst`: `[1]` execute, `[0]` load; never both set.
- `busy`  out  1  high from the cycle after accepted `start` until `done`.
- `done`  out  1  one-cycle pulse at end of drain.

## Operation

- FSM states:
  - IDLE: `start` goes to LOAD.
  - LOAD: runs `col+2` beats, then goes to EXEC, or to DRAIN if `n_q==0`.
  - EXEC: runs `n_q` beats, then goes to DRAIN.
  - DRAIN: runs `col+2` beats with `inst=0`, then goes to IDLE with `done`.
- Load ordering (column k captures load-stream beat `col+1-k`):
  - Beats 0 and 1 are pad: no SRAM read, `q_out=0`, `inst=2'b01`.
  - Beat `2+i` (i = 0..col-1) reads `key_base + (col-1-i)`, so the last column's key is sent first.
- Exec: beat j reads `q_base + j` and drives `inst=2'b10` with that data.
- Address arithmetic is modulo 2^addr_w; wrap-around is silent.
- An internal beat counter is `$clog2(max(col+2, 2^qcnt_w))` bits and resets to 0 at every state entry.
- `start` while busy is ignored; base and count registers stay unchanged.
- Reset at any point:
  - FSM to IDLE.
  - `inst=0`, `q_out=0`, `mem_rd=0`, `mem_addr=0`, `busy=0`, `done=0`.
  - An in-flight SRAM read is discarded.

## Timing

- Read issue at cycle t; `q_out`/`inst` for that beat are registered and valid at t+1.
  - `inst` is delayed internally by one stage so it stays aligned with `mem_rdata`.
- Accepted `start` at cycle 0 gives:
  - first `mem_rd`/`inst` beat-0 decision at cycle 1;
  - first `inst=2'b01` visible at cycle 2.
- Total latency from `start` to `done` is `1 + 2*(col+2) + n_q + 1` cycles with no stalls.
- `done` coincides with `busy` falling. A new `start` is accepted the cycle after `done`.
- Outputs are glitch-free registers; `q_out` holds its last value when `inst=0`, except after reset.

## Configuration

- `FEED_STALL_EN` defined adds input `stall` (1 bit).
  - While `stall` is high in EXEC, no read is issued, the beat counter holds, and a bubble (`inst=0`) is emitted one cycle later.
  - `stall` is ignored in LOAD and DRAIN, because the load beat counting in the columns must be contiguous.
  - Each stalled cycle adds one cycle to latency.
- Without `FEED_STALL_EN` the port does not exist and EXEC issues one beat per cycle unconditionally.

## Structure

- Shared package `npu_feed_pkg`:
  - state enum (IDLE, LOAD, EXEC, DRAIN);
  - instruction constants `INST_NOP=2'b00`, `INST_LOAD=2'b01`, `INST_EXEC=2'b10`;
  - function `load_len(col)=col+2`.
- One sub-module `feed_addr_gen` takes state, beat counter and bases, and produces `mem_rd`/`mem_addr` plus the pad flag. The top holds the FSM and the data/inst alignment register.

## Test plan

- col=8, key_base=0x100, n_q=4, q_base=0x200, SRAM word = address:
  - load beats at cycles 2..11;
  - beats 2..9 carry words 0x107..0x100;
  - exec cycles 12..15 carry 0x200..0x203 with `inst=2'b10`;
  - `done` at cycle 26.
- End-to-end with 8 `mac_col` instances: column k holds key 0x100+k after load. The psum stream from each column matches the software dot products for 4 queries.
- n_q=0: LOAD goes directly to DRAIN; no exec beats; `done` at cycle 22.
- `start` pulsed at cycles 0 and 5: second pulse ignored; one `done`; bases from cycle 0 used.
- Reset asserted at cycle 7 (mid-LOAD): the next cycle shows all outputs 0 and FSM IDLE. A fresh `start` then completes normally.
- `FEED_STALL_EN`, n_q=3, `stall` high for one cycle during the second exec beat: the exec sequence is 0x200, bubble, 0x201, 0x202, and `done` arrives one cycle later than without the stall.

Source files
------------

// File: rtl/npu_feed_pkg.sv
// Shared types and constants for the MAC column feeder: FSM states,
// column instruction encodings and the load-phase length.
package npu_feed_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    EXEC  = 2'd2,
    DRAIN = 2'd3
  } feed_state_e;

  localparam logic [1:0] INST_NOP  = 2'b00;
  localparam logic [1:0] INST_LOAD = 2'b01;
  localparam logic [1:0] INST_EXEC = 2'b10;

  // Two pad beats precede the col key beats so column k latches beat col+1-k.
  function automatic int load_len(input int col);
    return col + 2;
  endfunction

endpackage

// File: rtl/feed_addr_gen.sv
// SRAM read request generation for the feeder: keys are issued last column
// first during LOAD, queries in order during EXEC.
module feed_addr_gen
  import npu_feed_pkg::*;
#(
  parameter int col    = 8,
  parameter int addr_w = 11,
  parameter int cnt_w  = 8
) (
  input  feed_state_e       state,
  input  logic [cnt_w-1:0]  beat,
  input  logic [addr_w-1:0] key_base,
  input  logic [addr_w-1:0] q_base,
  input  logic              hold,
  output logic              mem_rd,
  output logic [addr_w-1:0] mem_addr,
  output logic              pad
);

  always_comb begin
    mem_rd   = 1'b0;
    mem_addr = '0;
    pad      = 1'b0;
    case (state)
      LOAD: begin
        if (beat < cnt_w'(2)) begin
          pad = 1'b1;
        end else begin
          // beat 2+i reads key_base + col-1-i
          mem_rd   = 1'b1;
          mem_addr = key_base + addr_w'(col + 1) - addr_w'(beat);
        end
      end
      EXEC: begin
        if (!hold) begin
          mem_rd   = 1'b1;
          mem_addr = q_base + addr_w'(beat);
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mac_col_feeder.sv
// Issue-side sequencer driving column 0 of the MAC chain with a load/execute
// stream. Optional macro FEED_STALL_EN adds a stall input honoured in EXEC.
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | two pad beats, then col key vectors (last column first)
// EXEC  | n_q query vectors with the execute instruction
// DRAIN | col+2 empty beats flushing the chain, then done
module mac_col_feeder
  import npu_feed_pkg::*;
#(
  parameter int bw     = 8,
  parameter int pr     = 8,
  parameter int col    = 8,
  parameter int addr_w = 11,
  parameter int qcnt_w = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
`ifdef FEED_STALL_EN
  input  logic                 stall,
`endif
  input  logic [addr_w-1:0]    key_base,
  input  logic [addr_w-1:0]    q_base,
  input  logic [qcnt_w-1:0]    n_q,
  output logic                 mem_rd,
  output logic [addr_w-1:0]    mem_addr,
  input  logic [pr*bw-1:0]     mem_rdata,
  output logic [pr*bw-1:0]     q_out,
  output logic [1:0]           inst,
  output logic                 busy,
  output logic                 done
);

  localparam int LLEN  = load_len(col);
  localparam int QMAX  = 2 ** qcnt_w;
  localparam int CNT_W = $clog2((LLEN > QMAX) ? LLEN : QMAX);

  feed_state_e        state, state_n;
  logic [CNT_W-1:0]   beat, beat_n;
  logic [addr_w-1:0]  key_r, qb_r;
  logic [qcnt_w-1:0]  nq_r;
  logic [1:0]         inst_n;
  logic               accept, hold, pad, last_drain;
  logic               fin_d1, rd_d, pad_d;
  logic [pr*bw-1:0]   q_hold, q_cur;

`ifdef FEED_STALL_EN
  assign hold = stall && (state == EXEC);
`else
  assign hold = 1'b0;
`endif

  // busy/done gating keeps the IDLE window until the done pulse has passed
  assign accept = start && (state == IDLE) && !busy && !done;

  feed_addr_gen #(
    .col    (col),
    .addr_w (addr_w),
    .cnt_w  (CNT_W)
  ) u_addr_gen (
    .state    (state),
    .beat     (beat),
    .key_base (key_r),
    .q_base   (qb_r),
    .hold     (hold),
    .mem_rd   (mem_rd),
    .mem_addr (mem_addr),
    .pad      (pad)
  );

  always_comb begin
    state_n    = state;
    beat_n     = beat + CNT_W'(1);
    inst_n     = INST_NOP;
    last_drain = 1'b0;
    case (state)
      IDLE: begin
        beat_n = '0;
        if (accept) state_n = LOAD;
      end
      LOAD: begin
        inst_n = INST_LOAD;
        if (beat == CNT_W'(LLEN - 1)) begin
          beat_n  = '0;
          state_n = (nq_r == '0) ? DRAIN : EXEC;
        end
      end
      EXEC: begin
        if (hold) begin
          beat_n = beat;
        end else begin
          inst_n = INST_EXEC;
          if (beat == CNT_W'(nq_r - qcnt_w'(1))) begin
            beat_n  = '0;
            state_n = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (beat == CNT_W'(LLEN - 1)) begin
          beat_n     = '0;
          state_n    = IDLE;
          last_drain = 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        beat_n  = '0;
      end
    endcase
  end

  // Read data arrives one cycle after issue; rd_d/pad_d/inst share that stage.
  assign q_cur = rd_d ? mem_rdata : (pad_d ? '0 : q_hold);
  assign q_out = q_cur;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      beat   <= '0;
      key_r  <= '0;
      qb_r   <= '0;
      nq_r   <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      fin_d1 <= 1'b0;
      inst   <= INST_NOP;
      rd_d   <= 1'b0;
      pad_d  <= 1'b0;
      q_hold <= '0;
    end else begin
      state  <= state_n;
      beat   <= beat_n;
      if (accept) begin
        key_r <= key_base;
        qb_r  <= q_base;
        nq_r  <= n_q;
        busy  <= 1'b1;
      end else if (fin_d1) begin
        busy  <= 1'b0;
      end
      fin_d1 <= last_drain;
      done   <= fin_d1;
      inst   <= inst_n;
      rd_d   <= mem_rd;
      pad_d  <= pad;
      q_hold <= q_cur;
    end
  end

endmodule

// File: tb/tb_mac_col_feeder.sv
// Directed bench for mac_col_feeder: per-cycle traces of each job are checked
// against hand-derived cycle numbers (col=8, SRAM word = its address).
module tb_mac_col_feeder;
  import npu_feed_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
`ifdef FEED_STALL_EN
  logic        stall = 1'b0;
`endif
  logic [10:0] key_base = '0;
  logic [10:0] q_base = '0;
  logic [7:0]  n_q = '0;
  logic        mem_rd;
  logic [10:0] mem_addr;
  logic [63:0] mem_rdata = '0;
  logic [63:0] q_out;
  logic [1:0]  inst;
  logic        busy;
  logic        done;

  int n_vec = 0;
  int n_err = 0;

  logic [1:0]  t_inst [0:63];
  logic [63:0] t_q    [0:63];
  logic        t_done [0:63];
  logic        t_busy [0:63];
  logic        t_rd   [0:63];
  logic [10:0] t_addr [0:63];
  feed_state_e t_st   [0:63];

  mac_col_feeder dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
`ifdef FEED_STALL_EN
    .stall     (stall),
`endif
    .key_base  (key_base),
    .q_base    (q_base),
    .n_q       (n_q),
    .mem_rd    (mem_rd),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .q_out     (q_out),
    .inst      (inst),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_rd) mem_rdata <= 64'(mem_addr);

  task automatic grab(input int c);
    t_inst[c] = inst;  t_q[c] = q_out;   t_done[c] = done;
    t_busy[c] = busy;  t_rd[c] = mem_rd; t_addr[c] = mem_addr;
    t_st[c] = dut.state;
  endtask

  // Cycle 0 carries start; optional second start (s2), reset (rc), stall (sc).
  task automatic run_trace(input logic [10:0] kb, input logic [10:0] qb,
                           input logic [7:0] nq, input int n, input int s2,
                           input int rc, input int sc);
    @(posedge clk); #1;
    key_base = kb; q_base = qb; n_q = nq; start = 1'b1;
    @(negedge clk); grab(0);
    for (int c = 1; c < n; c++) begin
      @(posedge clk); #1;
      start = (c == s2);
      reset = (c == rc);
      if (c == s2) begin key_base = 11'h300; q_base = 11'h380; n_q = 8'd9; end
`ifdef FEED_STALL_EN
      stall = (c == sc);
`else
      if (sc < 0 && c == sc) start = 1'b0;
`endif
      @(negedge clk); grab(c);
    end
    @(posedge clk); #1;
    start = 1'b0; reset = 1'b0;
`ifdef FEED_STALL_EN
    stall = 1'b0;
`endif
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    n_vec++; if (inst !== 2'b00)     begin n_err++; $display("FAIL rst_inst got %b exp 00", inst); end
    n_vec++; if (q_out !== 64'd0)    begin n_err++; $display("FAIL rst_q got %h exp 0", q_out); end
    n_vec++; if (mem_rd !== 1'b0)    begin n_err++; $display("FAIL rst_rd got %b exp 0", mem_rd); end
    n_vec++; if (mem_addr !== 11'd0) begin n_err++; $display("FAIL rst_addr got %h exp 0", mem_addr); end
    n_vec++; if (busy !== 1'b0)      begin n_err++; $display("FAIL rst_busy got %b exp 0", busy); end
    n_vec++; if (done !== 1'b0)      begin n_err++; $display("FAIL rst_done got %b exp 0", done); end
  endtask

  task automatic test_load_exec();
    logic [1:0]  ei;
    logic [63:0] eq;
    logic        er;
    logic [10:0] ea;
    run_trace(11'h100, 11'h200, 8'd4, 30, -1, -1, -1);
    for (int c = 0; c < 30; c++) begin
      ei = (c >= 2 && c <= 11) ? 2'b01 : (c >= 12 && c <= 15) ? 2'b10 : 2'b00;
      eq = (c <= 3) ? 64'd0 : (c <= 11) ? 64'(11'h107 - c + 4)
         : (c <= 15) ? 64'(11'h200 + c - 12) : 64'h203;
      er = (c >= 3 && c <= 14);
      ea = (c >= 3 && c <= 10) ? 11'(11'h107 - c + 3) : (c >= 11 && c <= 14) ? 11'(11'h200 + c - 11) : 11'd0;
      n_vec++; if (t_inst[c] !== ei) begin n_err++; $display("FAIL le_inst c=%0d got %b exp %b", c, t_inst[c], ei); end
      if (c >= 2) begin
        n_vec++; if (t_q[c] !== eq) begin n_err++; $display("FAIL le_q c=%0d got %h exp %h", c, t_q[c], eq); end
      end
      n_vec++; if (t_done[c] !== (c == 26)) begin n_err++; $display("FAIL le_done c=%0d got %b", c, t_done[c]); end
      n_vec++; if (t_busy[c] !== (c >= 1 && c <= 25)) begin n_err++; $display("FAIL le_busy c=%0d got %b", c, t_busy[c]); end
      n_vec++; if (t_rd[c] !== er) begin n_err++; $display("FAIL le_rd c=%0d got %b exp %b", c, t_rd[c], er); end
      if (er) begin
        n_vec++; if (t_addr[c] !== ea) begin n_err++; $display("FAIL le_addr c=%0d got %h exp %h", c, t_addr[c], ea); end
      end
    end
  endtask

  task automatic test_nq_zero();
    run_trace(11'h100, 11'h200, 8'd0, 26, -1, -1, -1);
    for (int c = 0; c < 26; c++) begin
      n_vec++; if (t_inst[c] !== ((c >= 2 && c <= 11) ? 2'b01 : 2'b00))
        begin n_err++; $display("FAIL nq0_inst c=%0d got %b", c, t_inst[c]); end
      n_vec++; if (t_done[c] !== (c == 22)) begin n_err++; $display("FAIL nq0_done c=%0d got %b", c, t_done[c]); end
      if (c >= 12) begin
        n_vec++; if (t_q[c] !== 64'h100) begin n_err++; $display("FAIL nq0_hold c=%0d got %h exp 100", c, t_q[c]); end
        n_vec++; if (t_rd[c] !== 1'b0) begin n_err++; $display("FAIL nq0_rd c=%0d got %b exp 0", c, t_rd[c]); end
      end
    end
  endtask

  task automatic test_double_start();
    int nd = 0;
    run_trace(11'h100, 11'h200, 8'd4, 40, 5, -1, -1);
    for (int c = 0; c < 40; c++) if (t_done[c] === 1'b1) nd++;
    n_vec++; if (nd !== 1) begin n_err++; $display("FAIL ds_done_count got %0d exp 1", nd); end
    n_vec++; if (t_done[26] !== 1'b1) begin n_err++; $display("FAIL ds_done26 got %b exp 1", t_done[26]); end
    for (int c = 4; c <= 15; c++) begin
      n_vec++;
      if (t_q[c] !== ((c <= 11) ? 64'(11'h107 - c + 4) : 64'(11'h200 + c - 12)))
        begin n_err++; $display("FAIL ds_q c=%0d got %h", c, t_q[c]); end
    end
  endtask

  task automatic test_reset_mid_load();
    run_trace(11'h100, 11'h200, 8'd4, 16, -1, 7, -1);
    n_vec++; if (t_inst[8] !== 2'b00)  begin n_err++; $display("FAIL rml_inst got %b exp 00", t_inst[8]); end
    n_vec++; if (t_q[8] !== 64'd0)     begin n_err++; $display("FAIL rml_q got %h exp 0", t_q[8]); end
    n_vec++; if (t_rd[8] !== 1'b0)     begin n_err++; $display("FAIL rml_rd got %b exp 0", t_rd[8]); end
    n_vec++; if (t_addr[8] !== 11'd0)  begin n_err++; $display("FAIL rml_addr got %h exp 0", t_addr[8]); end
    n_vec++; if (t_busy[8] !== 1'b0)   begin n_err++; $display("FAIL rml_busy got %b exp 0", t_busy[8]); end
    n_vec++; if (t_st[8] !== IDLE)     begin n_err++; $display("FAIL rml_state got %0d exp IDLE", t_st[8]); end
    n_vec++; if (t_busy[15] !== 1'b0)  begin n_err++; $display("FAIL rml_stay_idle got %b exp 0", t_busy[15]); end
    run_trace(11'h010, 11'h040, 8'd2, 28, -1, -1, -1);
    for (int c = 0; c < 28; c++) begin
      n_vec++; if (t_done[c] !== (c == 24)) begin n_err++; $display("FAIL rml_done c=%0d got %b", c, t_done[c]); end
    end
    n_vec++; if (t_q[4] !== 64'h017)  begin n_err++; $display("FAIL rml_key got %h exp 017", t_q[4]); end
    n_vec++; if (t_q[13] !== 64'h041) begin n_err++; $display("FAIL rml_exec got %h exp 041", t_q[13]); end
  endtask

`ifdef FEED_STALL_EN
  task automatic test_stall();
    logic [1:0]  ei [0:3];
    logic [63:0] eq [0:3];
    ei[0] = 2'b10; ei[1] = 2'b00; ei[2] = 2'b10; ei[3] = 2'b10;
    eq[0] = 64'h200; eq[1] = 64'h200; eq[2] = 64'h201; eq[3] = 64'h202;
    run_trace(11'h100, 11'h200, 8'd3, 30, -1, -1, 12);
    for (int k = 0; k < 4; k++) begin
      n_vec++; if (t_inst[12+k] !== ei[k]) begin n_err++; $display("FAIL st_inst c=%0d got %b exp %b", 12+k, t_inst[12+k], ei[k]); end
      n_vec++; if (t_q[12+k] !== eq[k]) begin n_err++; $display("FAIL st_q c=%0d got %h exp %h", 12+k, t_q[12+k], eq[k]); end
    end
    n_vec++; if (t_rd[12] !== 1'b0) begin n_err++; $display("FAIL st_rd got %b exp 0", t_rd[12]); end
    for (int c = 0; c < 30; c++) begin
      n_vec++; if (t_done[c] !== (c == 26)) begin n_err++; $display("FAIL st_done c=%0d got %b", c, t_done[c]); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_load_exec();
    test_nq_zero();
    test_double_start();
    test_reset_mid_load();
`ifdef FEED_STALL_EN
    test_stall();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
